// File: rtl/issue_arb.sv
// Round-robin issue arbiter with starvation override feeding a one-entry FU issue latch.
// Carries the shared ROB/RS type package so the block compiles on its own.
package ooop_types;
    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [7:0]           opcode;
        logic [15:0]          operand;
    } rs_entry_t;
endpackage

module issue_arb #(
    parameter int N_REQ        = 3,
    parameter int STARVE_LIMIT = 8,
    localparam int IDX_W       = $clog2(N_REQ),
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush_i,
    input  logic                                 recover_i,
    input  logic [ooop_types::ROB_DEPTH-1:0]     live_tag_i,
    input  logic [N_REQ-1:0]                     req_valid_i,
    input  ooop_types::rs_entry_t [N_REQ-1:0]    req_entry_i,
    output logic [N_REQ-1:0]                     req_ready_o,
    output logic                                 fu_valid_o,
    output ooop_types::rs_entry_t                fu_entry_o,
    output logic [IDX_W-1:0]                     fu_src_o,
    input  logic                                 fu_ready_i
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [IDX_W:0]   N_EXT = (IDX_W + 1)'(N_REQ);

    logic                  lat_vld_p1;
    ooop_types::rs_entry_t lat_entry_p1;
    logic [IDX_W-1:0]      lat_src_p1;
    logic [IDX_W-1:0]      rr_ptr;
    logic [CNT_W-1:0]      wait_cnt [N_REQ];

    logic                  can_accept;
    logic                  grant;
    logic [IDX_W-1:0]      win;
    logic                  win_found;

    assign can_accept = !lat_vld_p1 || fu_ready_i;

    // Starved requesters win lowest-index-first; otherwise scan from rr_ptr with wrap.
    always_comb begin : pick
        logic [IDX_W:0] slot;
        win       = '0;
        win_found = 1'b0;
        slot      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && req_valid_i[i] && wait_cnt[i] == LIMIT) begin
                win       = IDX_W'(i);
                win_found = 1'b1;
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            slot = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (slot >= N_EXT) begin
                slot = slot - N_EXT;
            end
            if (!win_found && req_valid_i[slot[IDX_W-1:0]]) begin
                win       = slot[IDX_W-1:0];
                win_found = 1'b1;
            end
        end
    end

    assign grant = rst_n && can_accept && !flush_i && !recover_i && win_found;

    always_comb begin
        req_ready_o = '0;
        if (grant) begin
            req_ready_o[win] = 1'b1;
        end
    end

    // p0 -> p1: grant selection captured into the issue latch
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            lat_vld_p1   <= 1'b0;
            lat_entry_p1 <= '0;
            lat_src_p1   <= '0;
            rr_ptr       <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            if (!recover_i) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (!req_valid_i[i] || req_ready_o[i]) begin
                        wait_cnt[i] <= '0;
                    end else if (wait_cnt[i] != LIMIT) begin
                        wait_cnt[i] <= wait_cnt[i] + 1'b1;
                    end
                end
            end
            if (grant) begin
                lat_vld_p1   <= 1'b1;
                lat_entry_p1 <= req_entry_i[win];
                lat_src_p1   <= win;
                rr_ptr       <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
            end else if (lat_vld_p1 && fu_ready_i) begin
                lat_vld_p1   <= 1'b0;
                lat_entry_p1 <= '0;
            end else if (recover_i && lat_vld_p1 && !live_tag_i[lat_entry_p1.rob_tag]) begin
                lat_vld_p1   <= 1'b0;
                lat_entry_p1 <= '0;
            end
        end
    end

    assign fu_valid_o = lat_vld_p1;
    assign fu_entry_o = lat_entry_p1;
    assign fu_src_o   = lat_src_p1;

endmodule
